// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: 64-bit AXI-stream RX typedefs, TLP fmt/type codes, the decoded
// PIO request record and the RX engine state encoding.
// Optional feature macro: PIO_RX_64BIT_ADDR_EN (4DW MemRd64/MemWr64 support).
package pcie_tlp_pkg;

    typedef logic        PCIE_TVALID64;
    typedef logic        PCIE_TREADY64;
    typedef logic        PCIE_TLAST64;
    typedef logic [7:0]  PCIE_TKEEP64;
    typedef logic [63:0] PCIE_TDATA64;
    typedef logic [21:0] PCIE_TUSER64_RX;

    localparam logic [6:0] FT_MRD32 = 7'h00;
    localparam logic [6:0] FT_MWR32 = 7'h40;
    localparam logic [6:0] FT_MRD64 = 7'h20;
    localparam logic [6:0] FT_MWR64 = 7'h60;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [31:0] data;
        logic [6:0]  bar;
    } pio_req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR1  = 3'd1,
`ifdef PIO_RX_64BIT_ADDR_EN
        HDR2  = 3'd2,
`endif
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } pio_rx_state_t;

endpackage

// File: rtl/pio_rx_engine.sv
// pio_rx_engine: decodes MemRd/MemWr TLPs from a 64-bit AXI-stream RX port into
// a single held request; unsupported or malformed TLPs are drained and counted.
// Optional feature macro: PIO_RX_64BIT_ADDR_EN (adds 4DW requests and HDR2).
module pio_rx_engine
    import pcie_tlp_pkg::*;
(
    input  logic           pcie_clk,
    input  logic           sys_rst_n,
    input  PCIE_TVALID64   pcie_rx_tvalid,
    output PCIE_TREADY64   pcie_rx_tready,
    input  PCIE_TLAST64    pcie_rx_tlast,
    input  PCIE_TKEEP64    pcie_rx_tkeep,
    input  PCIE_TDATA64    pcie_rx_tdata,
    input  PCIE_TUSER64_RX pcie_rx_tuser,
    output logic           req_valid,
    input  logic           req_ready,
    output logic           req_wr,
    output logic [31:0]    req_addr,
    output logic [9:0]     req_len,
    output logic [15:0]    req_rid,
    output logic [7:0]     req_tag,
    output logic [3:0]     req_be,
    output logic [31:0]    req_data,
    output logic [6:0]     req_bar,
    output logic [15:0]    drop_cnt
);

    pio_rx_state_t state, state_nxt;
    pio_req_t      req_q, req_nxt;
    logic          hdr_4dw_q, hdr_4dw_nxt;
    logic          tready_q;
    logic [15:0]   drop_q;
    logic          drop_inc;
    logic          beat;
    logic [6:0]    fmt_type;
    logic [9:0]    hdr_len;
    logic          supported;
    logic          unused_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat     = pcie_rx_tvalid & tready_q;
    assign fmt_type = pcie_rx_tdata[30:24];
    assign hdr_len  = pcie_rx_tdata[9:0];

    // Byte enables and the remaining sideband/header bits carry nothing this engine needs.
    assign unused_ok = ^{pcie_rx_tkeep, pcie_rx_tuser[21:9], pcie_rx_tuser[1:0],
                         pcie_rx_tdata[39:36], pcie_rx_tdata[31], pcie_rx_tdata[23:10]};

    // Classify a beat-0 header; writes are only served as single-DW.
    always_comb begin
        supported = 1'b0;
        case (fmt_type)
            FT_MRD32: supported = 1'b1;
            FT_MWR32: supported = (hdr_len == 10'd1);
`ifdef PIO_RX_64BIT_ADDR_EN
            FT_MRD64: supported = 1'b1;
            FT_MWR64: supported = (hdr_len == 10'd1);
`endif
            default:  supported = 1'b0;
        endcase
    end

    // Next-state, request capture and drop decision.
    always_comb begin
        state_nxt   = state;
        req_nxt     = req_q;
        hdr_4dw_nxt = hdr_4dw_q;
        drop_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (pcie_rx_tlast) begin
                        drop_inc = 1'b1;
                    end else if (supported) begin
                        state_nxt   = HDR1;
                        hdr_4dw_nxt = fmt_type[5];
                        req_nxt     = '0;
                        req_nxt.wr  = fmt_type[6];
                        req_nxt.len = hdr_len;
                        req_nxt.rid = pcie_rx_tdata[63:48];
                        req_nxt.tag = pcie_rx_tdata[47:40];
                        req_nxt.be  = pcie_rx_tdata[35:32];
                        req_nxt.bar = pcie_rx_tuser[8:2];
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            HDR1: begin
                if (beat) begin
                    if (!hdr_4dw_q) begin
                        if (pcie_rx_tlast) begin
                            state_nxt    = HOLD;
                            req_nxt.addr = {pcie_rx_tdata[31:2], 2'b00};
                            req_nxt.data = req_q.wr ? pcie_rx_tdata[63:32] : 32'd0;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end
`ifdef PIO_RX_64BIT_ADDR_EN
                    else if (req_q.wr) begin
                        // Write data still to come, so tlast here means a short TLP.
                        if (pcie_rx_tlast) begin
                            state_nxt = IDLE;
                            drop_inc  = 1'b1;
                        end else begin
                            state_nxt    = HDR2;
                            req_nxt.addr = {pcie_rx_tdata[63:34], 2'b00};
                        end
                    end else begin
                        if (pcie_rx_tlast) begin
                            state_nxt    = HOLD;
                            req_nxt.addr = {pcie_rx_tdata[63:34], 2'b00};
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end
`else
                    else begin
                        state_nxt = DRAIN;
                    end
`endif
                end
            end
`ifdef PIO_RX_64BIT_ADDR_EN
            HDR2: begin
                if (beat) begin
                    if (pcie_rx_tlast) begin
                        state_nxt    = HOLD;
                        req_nxt.data = pcie_rx_tdata[31:0];
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
`endif
            DRAIN: begin
                if (beat && pcie_rx_tlast) begin
                    state_nxt = IDLE;
                    drop_inc  = 1'b1;
                end
            end
            HOLD: begin
                if (req_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request record, registered tready and saturating drop counter.
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            hdr_4dw_q <= 1'b0;
            tready_q  <= 1'b0;
            drop_q    <= 16'd0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_nxt;
            hdr_4dw_q <= hdr_4dw_nxt;
            tready_q  <= (state_nxt != HOLD);
            if (drop_inc) begin
                drop_q <= sat_inc(drop_q);
            end
        end
    end

    assign pcie_rx_tready = tready_q;
    assign req_valid      = (state == HOLD);
    assign req_wr         = req_q.wr;
    assign req_addr       = req_q.addr;
    assign req_len        = req_q.len;
    assign req_rid        = req_q.rid;
    assign req_tag        = req_q.tag;
    assign req_be         = req_q.be;
    assign req_data       = req_q.data;
    assign req_bar        = req_q.bar;
    assign drop_cnt       = drop_q;

endmodule

// File: doc/pio_rx_engine.md
PIO_RX_ENGINE -- requirements
Module: pio_rx_engine

Interface
REQ-001 SHALL have port pcie_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port pcie_rx_tvalid, input, 1 bit: RX beat valid.
REQ-004 SHALL have port pcie_rx_tready, output, 1 bit: RX beat accept.
REQ-005 SHALL have port pcie_rx_tlast, input, 1 bit: last beat of a TLP.
REQ-006 SHALL have port pcie_rx_tkeep, input, 8 bits: byte enables, ignored except on the final beat.
REQ-007 SHALL have port pcie_rx_tdata, input, 64 bits: TLP data.
REQ-008 SHALL have port pcie_rx_tuser, input, 22 bits: RX sideband; bits [8:2] carry the BAR hit.
REQ-009 SHALL have port req_valid, output, 1 bit: decoded request available.
REQ-010 SHALL have port req_ready, input, 1 bit: consumer accepts the request.
REQ-011 SHALL have the request outputs req_wr (1), req_addr (32), req_len (10), req_rid (16), req_tag (8), req_be (4), req_data (32) and req_bar (7).
REQ-012 SHALL have port drop_cnt, output, 16 bits: count of discarded TLPs.

Function
REQ-013 A beat SHALL transfer only on a cycle where tvalid and tready are both 1.
REQ-014 Beat 0 SHALL decode as follows:
- tdata[30:24] = fmt/type.
- tdata[9:0] = length.
- tdata[63:48] = requester ID.
- tdata[47:40] = tag.
- tdata[35:32] = first BE.
- tuser[8:2] = BAR hit.
REQ-015 Supported fmt/type values SHALL be MemRd32 0x00 and MemWr32 0x40; MemWr32 is supported only with length 1.
REQ-016 For 3DW TLPs, beat 1 SHALL decode as: tdata[31:2] = address[31:2], address[1:0] forced to 0; tdata[63:32] = write data.
REQ-017 The state machine SHALL have states IDLE, HDR1, HDR2, DRAIN and HOLD.
REQ-018 IDLE SHALL transition on beat 0 as follows:
- Supported TLP with tlast=0 -> HDR1.
- Unsupported TLP with tlast=0 -> DRAIN.
- Any TLP with tlast=1 (truncated) -> IDLE, with drop_cnt+1.
REQ-019 HDR1 SHALL behave as follows:
- 3DW TLP -> HOLD, with the request registered.
- 4DW TLP -> HDR2.
- tlast on an unexpected beat -> IDLE, with drop_cnt+1.
- Extra beats without tlast -> DRAIN.
REQ-020 DRAIN SHALL accept beats until tlast, then go to IDLE; drop_cnt SHALL increment by 1 per discarded TLP.
REQ-021 HOLD SHALL hold tready=0 and req_valid=1, and return to IDLE on the cycle req_ready=1.
REQ-022 req_valid SHALL assert one cycle after the last header/data beat is accepted.
REQ-023 Request outputs SHALL remain stable while req_valid=1 and req_ready=0.
REQ-024 tready SHALL be 1 in IDLE, HDR1, HDR2 and DRAIN.
REQ-025 For MemRd requests, req_data SHALL be 0 and req_wr SHALL be 0.
REQ-026 drop_cnt SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-027 tvalid=0 in the middle of a TLP SHALL stall the state machine with no state change.

Reset
REQ-028 Asserting sys_rst_n low SHALL immediately set all of the following, regardless of state, including mid-TLP and during HOLD:
- State = IDLE.
- tready = 0, req_valid = 0, drop_cnt = 0.
- All req_* fields = 0.
REQ-029 tready SHALL go to 1 on the first clock edge after sys_rst_n deasserts.
REQ-030 A partial TLP in flight at reset SHALL be lost and SHALL NOT be counted in drop_cnt.

Configuration
REQ-031 The macro PIO_RX_64BIT_ADDR_EN SHALL control 4DW request support.
REQ-032 With PIO_RX_64BIT_ADDR_EN defined:
- MemRd64 (0x20) and MemWr64 (0x60, length 1) SHALL be supported.
- HDR1 beat: tdata[63:34] = address[31:2]; the upper address DW in tdata[31:0] is ignored.
- MemRd64 SHALL complete from HDR1 to HOLD.
- MemWr64 SHALL go to HDR2, where tdata[31:0] = write data.
REQ-033 Without PIO_RX_64BIT_ADDR_EN, fmt/type 0x20 and 0x60 SHALL be unsupported and drained, and the HDR2 state SHALL NOT be present.

Structure
REQ-034 The AXI-stream typedefs (PCIE_TVALID64, PCIE_TREADY64, PCIE_TLAST64, PCIE_TKEEP64, PCIE_TDATA64, PCIE_TUSER64_RX) SHALL come from pcie_tlp_pkg.
REQ-035 The fmt/type constants and a pio_req_t request struct SHALL be added to pcie_tlp_pkg.
REQ-036 The block SHALL be a single module with no sub-modules.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- MemRd32: beat 0 = 0x0000_0F0F_00000001, beat 1 = 0xXXXXXXXX_00AA_F800 with tlast, tuser bits [8:2] = 0000001 -> req_valid next cycle; req_wr=0, req_addr=0x00AAF800, req_len=1, req_rid=0x0000, req_tag=0x0F, req_be=0xF, req_bar=0x01.
- MemWr32 length 1, data DW 0xDEADBEEF, req_ready held 0 for 5 cycles -> tready=0 and outputs stable for those 5 cycles; req_data=0xDEADBEEF; handshake completes, then tready=1.
- MemWr32 length 4 (4 beats) -> drained; no req_valid; drop_cnt=1; a following MemRd32 is decoded correctly.
- With the macro: MemWr64, address lo DW 0x1000_0004 -> req_addr=0x10000004 after 3 beats. Without the macro: the same TLP gives drop_cnt+1.
- sys_rst_n pulsed low after beat 0 of a MemRd32 -> outputs 0 asynchronously; the next full TLP decodes normally; drop_cnt=0.
- drop_cnt preloaded to 0xFFFF via repeated drops -> stays at 0xFFFF after a further drop.
